// File: rtl/dmem_load_unit.sv
// Read side of the byte-banked data memory: single outstanding load, lane select and extension.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word loads answer with rsp_err=1 and skip the banks.
module dmem_load_unit #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [7:0]        mem_rdata1,
  input  logic [7:0]        mem_rdata2,
  input  logic [7:0]        mem_rdata3,
  input  logic [7:0]        mem_rdata4,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic [ADDR_W-3:0] r_word_addr;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [31:0]       r_rsp_data;

  logic              w_misalign;
  logic [31:0]       w_word;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic [31:0]       w_load_data;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_word_addr <= '0;
      r_lane      <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_word_addr <= req_addr[ADDR_W-1:2];
            r_lane      <= req_addr[1:0];
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            // No-op and trapped loads answer immediately with zero data.
            if ((req_size == SZ_NONE) || w_misalign) begin
              r_rsp_data <= '0;
              r_state    <= S_RESP;
            end else begin
              r_state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == LAT_LAST) begin
            r_rsp_data <= w_load_data;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_rsp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_err <= 1'b0;
    end else if ((r_state == S_IDLE) && req_valid) begin
      r_rsp_err <= w_misalign;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    w_word      = {mem_rdata4, mem_rdata3, mem_rdata2, mem_rdata1};
    w_half      = r_lane[1] ? w_word[31:16] : w_word[15:0];
    w_byte      = '0;
    w_load_data = '0;
    case (r_lane)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    case (r_size)
      SZ_BYTE: w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
      SZ_WORD: w_load_data = w_word;
      default: w_load_data = '0;
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign mem_en    = (r_state == S_ISSUE);
  assign mem_addr  = r_word_addr;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_dmem_load_unit.sv
// Bench for dmem_load_unit: latency-accurate bank model and a behavioural load reference.
module tb_dmem_load_unit;

  localparam int RD_LAT = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_rdata1, mem_rdata2, mem_rdata3, mem_rdata4;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] bank_mem [1024];
  int unsigned en_count = 0;
  logic [9:0]  last_mem_addr = '0;
  logic [9:0]  pend_addr = '0;
  int unsigned pend_cnt = 0;

  dmem_load_unit #(.ADDR_W(12), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
    .mem_rdata3(mem_rdata3), .mem_rdata4(mem_rdata4),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Bank model: data is valid for exactly one cycle, RD_LAT cycles after the strobe.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      en_count++;
      last_mem_addr = mem_addr;
      pend_addr     = mem_addr;
      pend_cnt      = RD_LAT;
    end
  end

  always @(posedge clk) begin
    logic [31:0] v;
    #1;
    v = $urandom;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) v = bank_mem[pend_addr];
    end
    {mem_rdata4, mem_rdata3, mem_rdata2, mem_rdata1} = v;
  end

  // Returns {err, data} for a load of size sz at byte address a from memory word w.
  function automatic logic [32:0] model(input logic [11:0] a, input logic [1:0] sz,
                                        input logic u, input logic [31:0] w);
    int unsigned v;
    int unsigned lane;
    lane = a % 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && (lane % 2) == 1) || (sz == 2'd2 && lane != 0)) return {1'b1, 32'h0};
`endif
    case (sz)
      2'd0: begin
        v = (w >> (8 * lane)) % 256;
        if (!u && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (w >> (16 * (lane / 2))) % 65536;
        if (!u && v >= 32768) v = v + 32'hFFFF_0000;
      end
      2'd2:    v = w;
      default: v = 0;
    endcase
    return {1'b0, v};
  endfunction

  task automatic run_load(input logic [11:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] w, input int unsigned hold, input string tag);
    logic [32:0] exp;
    bit          access;
    int unsigned en0, k, exp_lat;
    exp     = model(a, sz, u, w);
    access  = (sz != 2'b11) && !exp[32];
    exp_lat = access ? 2 + RD_LAT : 1;
    bank_mem[a[11:2]] = w;
    en0 = en_count;
    @(posedge clk) #1;
    req_valid = 1'b1; req_addr = a; req_size = sz; req_unsigned = u;
    rsp_ready = (hold == 0);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
    end
    @(posedge clk) #1;
    req_valid = 1'b0; req_addr = 12'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    k = 1;
    while (rsp_valid !== 1'b1 && k < 40) begin
      @(posedge clk) #1;
      k++;
    end
    checks++;
    if (k != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", tag, k, exp_lat);
    end
    checks++;
    if (rsp_data !== exp[31:0]) begin
      errors++; $display("FAIL %s rsp_data: got %h want %h", tag, rsp_data, exp[31:0]);
    end
    checks++;
    if (rsp_err !== exp[32]) begin
      errors++; $display("FAIL %s rsp_err: got %b want %b", tag, rsp_err, exp[32]);
    end
    if (access) begin
      checks++;
      if (last_mem_addr !== a[11:2]) begin
        errors++; $display("FAIL %s mem_addr: got %h want %h", tag, last_mem_addr, a[11:2]);
      end
    end
    for (int i = 0; i < int'(hold); i++) begin
      req_valid = 1'b1; req_addr = 12'($urandom); req_size = 2'd2;
      @(posedge clk) #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[31:0] || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: got valid=%b data=%h ready=%b want 1 %h 0",
                 tag, i, rsp_valid, rsp_data, req_ready, exp[31:0]);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk) #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake: got valid=%b ready=%b want 0 1", tag, rsp_valid, req_ready);
    end
    checks++;
    if (en_count - en0 != (access ? 1 : 0)) begin
      errors++; $display("FAIL %s mem_en_cycles: got %0d want %0d", tag, en_count - en0, access ? 1 : 0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b en=%b want 1 0 0", req_ready, rsp_valid, mem_en);
    end
    checks++;
    if (rsp_data !== 32'h0 || rsp_err !== 1'b0 || mem_addr !== 10'h0) begin
      errors++;
      $display("FAIL reset_data: got data=%h err=%b addr=%h want 0 0 0", rsp_data, rsp_err, mem_addr);
    end
  endtask

  task automatic test_directed;
    run_load(12'h004, 2'd2, 1'b0, 32'h4433_2211, 0, "word_004");
    run_load(12'h003, 2'd0, 1'b0, 32'h8012_3456, 0, "byte_s");
    run_load(12'h003, 2'd0, 1'b1, 32'h8012_3456, 0, "byte_u");
    run_load(12'h002, 2'd1, 1'b0, 32'h7FFF_A5A5, 0, "half_7fff");
    run_load(12'h002, 2'd1, 1'b0, 32'h8001_5A5A, 0, "half_8001");
    run_load(12'h001, 2'd1, 1'b1, 32'hCAFE_BEEF, 0, "half_lo_u");
  endtask

  task automatic test_hold;
    run_load(12'h10C, 2'd2, 1'b0, 32'hDEAD_BEEF, 5, "hold5");
  endtask

  task automatic test_none;
    run_load(12'h0A8, 2'd3, 1'b0, 32'h1234_5678, 0, "none");
    run_load(12'h0AB, 2'd3, 1'b1, 32'h1234_5678, 2, "none_hold");
  endtask

  task automatic test_misalign;
    run_load(12'h006, 2'd2, 1'b0, 32'h0BAD_F00D, 0, "word_006");
    run_load(12'h0F3, 2'd1, 1'b0, 32'h9988_7766, 1, "half_odd");
  endtask

  task automatic test_reset_wait;
    int unsigned en0;
    bank_mem[12'h3FC >> 2] = 32'h1111_2222;
    @(posedge clk) #1;
    req_valid = 1'b1; req_addr = 12'h3FC; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk) #1;
    req_valid = 1'b0;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    en0 = en_count;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_addr !== 10'h0 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait: got ready=%b valid=%b addr=%h data=%h want 1 0 000 0",
               req_ready, rsp_valid, mem_addr, rsp_data);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL rst_wait_idle%0d: got valid=%b ready=%b want 0 1", i, rsp_valid, req_ready);
      end
    end
    checks++;
    if (en_count != en0) begin
      errors++; $display("FAIL rst_wait_mem_en: got %0d strobes want 0", en_count - en0);
    end
    run_load(12'h3FC, 2'd2, 1'b0, 32'h1111_2222, 0, "after_rst");
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      run_load(12'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3), "rand");
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; rsp_ready = 1'b0;
    {mem_rdata4, mem_rdata3, mem_rdata2, mem_rdata1} = '0;
    for (int i = 0; i < 1024; i++) bank_mem[i] = $urandom;
    test_reset;
    test_directed;
    test_hold;
    test_none;
    test_misalign;
    test_reset_wait;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
